// File: rtl/vga_timing_controller.sv
// Parametrised VGA raster generator: pixel-rate clock enable, programmable sync
// polarity, look-ahead pixel requests and blanked RGB/sync to the pins.
module vga_timing_controller #(
  parameter int DEPTH    = 4,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int AW       = 19,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int LATENCY  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DEPTH-1:0] r,
  input  logic [DEPTH-1:0] g,
  input  logic [DEPTH-1:0] b,
  output logic [XW-1:0]    x,
  output logic [YW-1:0]    y,
  output logic [AW-1:0]    address,
  output logic             visible,
  output logic             pixelTick,
  output logic             lineStart,
  output logic             frameStart,
  output logic             vblankStart,
  output logic [DEPTH-1:0] vgaR,
  output logic [DEPTH-1:0] vgaG,
  output logic [DEPTH-1:0] vgaB,
  output logic             hSync,
  output logic             vSync
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIVW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [XW:0]     HT       = (XW+1)'(H_TOTAL);
  localparam logic [XW:0]     HA       = (XW+1)'(H_ACTIVE);
  localparam logic [XW:0]     HS_BEG   = (XW+1)'(H_ACTIVE + H_FRONT);
  localparam logic [XW:0]     HS_END   = (XW+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [YW:0]     VA       = (YW+1)'(V_ACTIVE);
  localparam logic [YW:0]     VS_BEG   = (YW+1)'(V_ACTIVE + V_FRONT);
  localparam logic [YW:0]     VS_END   = (YW+1)'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [XW:0]     LEAD     = (XW+1)'(LATENCY + 1);

  typedef struct packed {
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [AW-1:0]    addr;
    logic             vis;
    logic             hs;
    logic             vs;
    logic [DEPTH-1:0] r;
    logic [DEPTH-1:0] g;
    logic [DEPTH-1:0] b;
  } px_t;

  localparam px_t PX_RST = '{x: '0, y: '0, addr: '0, vis: 1'b0, hs: !H_POL, vs: !V_POL,
                             r: '0, g: '0, b: '0};

  logic [DIVW-1:0] div_q, div_d;
  logic [XW-1:0]   hc_q, hc_d;
  logic [YW-1:0]   vc_q, vc_d;
  px_t             px_q, px_d;

  logic          tick, load, hc_last, vc_last, active;
  logic [XW:0]   hc_w, lsum;
  logic [YW:0]   vc_w;
  logic [XW-1:0] lx;
  logic [YW-1:0] ly;

  assign tick    = enable && (div_q == DIV_LAST);
  assign load    = tick || !enable;
  assign hc_last = (hc_q == XW'(H_TOTAL - 1));
  assign vc_last = (vc_q == YW'(V_TOTAL - 1));
  assign hc_w    = {1'b0, hc_q};
  assign vc_w    = {1'b0, vc_q};
  assign active  = (hc_w < HA) && (vc_w < VA);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    div_d = '0;
    hc_d  = '0;
    vc_d  = '0;
    px_d  = PX_RST;
    lsum  = hc_w + LEAD;
    lx    = '0;
    ly    = '0;
    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIVW'(1);
      hc_d  = hc_last ? '0 : hc_q + XW'(1);
      vc_d  = hc_last ? (vc_last ? '0 : vc_q + YW'(1)) : vc_q;

      // Look-ahead never spans more than one line because LATENCY+1 < H_TOTAL.
      if (lsum >= HT) begin
        lx = XW'(lsum - HT);
        ly = vc_last ? '0 : vc_q + YW'(1);
      end else begin
        lx = lsum[XW-1:0];
        ly = vc_q;
      end

      px_d.x    = lx;
      px_d.y    = ly;
      px_d.vis  = ({1'b0, lx} < HA) && ({1'b0, ly} < VA);
      px_d.addr = px_d.vis ? AW'(ly) * AW'(H_ACTIVE) + AW'(lx) : '0;
      px_d.hs   = (hc_w >= HS_BEG && hc_w < HS_END) ? H_POL : !H_POL;
      px_d.vs   = (vc_w >= VS_BEG && vc_w < VS_END) ? V_POL : !V_POL;
      px_d.r    = active ? r : '0;
      px_d.g    = active ? g : '0;
      px_d.b    = active ? b : '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      hc_q  <= '0;
      vc_q  <= '0;
      px_q  <= PX_RST;
    end else begin
      div_q <= div_d;
      if (load) begin
        hc_q <= hc_d;
        vc_q <= vc_d;
        px_q <= px_d;
      end
    end
  end

  // Pulses flag the tick whose counter update lands on the named position.
  assign pixelTick   = tick;
  assign lineStart   = tick && hc_last;
  assign frameStart  = tick && hc_last && vc_last;
  assign vblankStart = tick && hc_last && (vc_q == YW'(V_ACTIVE - 1));

  assign x       = px_q.x;
  assign y       = px_q.y;
  assign address = px_q.addr;
  assign visible = px_q.vis;
  assign hSync   = px_q.hs;
  assign vSync   = px_q.vs;
  assign vgaR    = px_q.r;
  assign vgaG    = px_q.g;
  assign vgaB    = px_q.b;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller: three configurations checked every cycle against
// a tick-count model of the raster, plus hand-computed timing and wrap expectations.
module tb_vga_timing_controller;

  localparam int N = 3;

  typedef struct {
    int ha, hf, hsw, hb, va, vf, vsw, vb, hpol, vpol, div, lat;
  } cfg_t;

  typedef struct {
    int x, y, addr, vis, pt, ls, fs, vbs, hs, vs, r, g, b;
  } exp_t;

  // 0: full 640x480 defaults; 1: small raster, positive syncs, CLK_DIV 1, LATENCY 2;
  // 2: small raster, CLK_DIV 3, LATENCY 3.
  function automatic cfg_t get_cfg(int i);
    cfg_t c;
    case (i)
      0:       c = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, 0};
      1:       c = '{20, 3, 4, 5, 6, 2, 2, 3, 1, 1, 1, 2};
      default: c = '{20, 3, 4, 5, 6, 2, 2, 3, 0, 0, 3, 3};
    endcase
    return c;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;

  logic [3:0]  r0, r1, r2;
  logic [3:0]  r_all [N];
  logic [3:0]  g_in [N];
  logic [3:0]  b_in [N];
  logic [3:0]  sh [3];
  logic [9:0]  x_w [N];
  logic [9:0]  y_w [N];
  logic [18:0] addr_w [N];
  logic        vis_w [N];
  logic        pt_w [N];
  logic        ls_w [N];
  logic        fs_w [N];
  logic        vbs_w [N];
  logic        hs_w [N];
  logic        vs_w [N];
  logic [3:0]  vr_w [N];
  logic [3:0]  vg_w [N];
  logic [3:0]  vbl_w [N];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vga_timing_controller u_a (
    .clk(clk), .reset(rst), .enable(en), .r(r0), .g(g_in[0]), .b(b_in[0]),
    .x(x_w[0]), .y(y_w[0]), .address(addr_w[0]), .visible(vis_w[0]), .pixelTick(pt_w[0]),
    .lineStart(ls_w[0]), .frameStart(fs_w[0]), .vblankStart(vbs_w[0]),
    .vgaR(vr_w[0]), .vgaG(vg_w[0]), .vgaB(vbl_w[0]), .hSync(hs_w[0]), .vSync(vs_w[0])
  );

  vga_timing_controller #(
    .H_ACTIVE(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1), .LATENCY(2)
  ) u_b (
    .clk(clk), .reset(rst), .enable(en), .r(r1), .g(g_in[1]), .b(b_in[1]),
    .x(x_w[1]), .y(y_w[1]), .address(addr_w[1]), .visible(vis_w[1]), .pixelTick(pt_w[1]),
    .lineStart(ls_w[1]), .frameStart(fs_w[1]), .vblankStart(vbs_w[1]),
    .vgaR(vr_w[1]), .vgaG(vg_w[1]), .vgaB(vbl_w[1]), .hSync(hs_w[1]), .vSync(vs_w[1])
  );

  vga_timing_controller #(
    .H_ACTIVE(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(3), .LATENCY(3)
  ) u_c (
    .clk(clk), .reset(rst), .enable(en), .r(r2), .g(g_in[2]), .b(b_in[2]),
    .x(x_w[2]), .y(y_w[2]), .address(addr_w[2]), .visible(vis_w[2]), .pixelTick(pt_w[2]),
    .lineStart(ls_w[2]), .frameStart(fs_w[2]), .vblankStart(vbs_w[2]),
    .vgaR(vr_w[2]), .vgaG(vg_w[2]), .vgaB(vbl_w[2]), .hSync(hs_w[2]), .vSync(vs_w[2])
  );

  // Pixel sources: A returns its column combinationally, C returns it three ticks late.
  assign r0 = x_w[0][3:0];
  assign r2 = sh[2];

  always @(posedge clk) begin
    if (pt_w[2]) begin
      sh[0] <= x_w[2][3:0];
      sh[1] <= sh[0];
      sh[2] <= sh[1];
    end
  end

  always_comb begin
    r_all[0] = r0;
    r_all[1] = r1;
    r_all[2] = r2;
  end

  // Model state: clk edges since the raster (re)started, and the colour taken at the last tick.
  int         m [N];
  logic [3:0] rl [N];
  logic [3:0] gl [N];
  logic [3:0] bl [N];
  cfg_t       mc;

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < N; i++) begin
      mc = get_cfg(i);
      if (rst || !en) begin
        m[i] <= 0;
      end else begin
        if (m[i] % mc.div == mc.div - 1) begin
          rl[i] <= r_all[i];
          gl[i] <= g_in[i];
          bl[i] <= b_in[i];
        end
        m[i] <= m[i] + 1;
      end
    end
  end

  function automatic exp_t model(cfg_t c, int mm, logic e, logic [3:0] rr, logic [3:0] gg,
                                 logic [3:0] bb);
    exp_t o;
    int ht, vt, ft, t, nx, p, ph, pv, l, lx, ly, act;
    ht   = c.ha + c.hf + c.hsw + c.hb;
    vt   = c.va + c.vf + c.vsw + c.vb;
    ft   = ht * vt;
    t    = mm / c.div;
    o.pt = (e && (mm % c.div == c.div - 1)) ? 1 : 0;
    nx   = (t + 1) % ft;
    o.ls = (o.pt == 1 && nx % ht == 0) ? 1 : 0;
    o.fs = (o.pt == 1 && nx == 0) ? 1 : 0;
    o.vbs = (o.pt == 1 && nx == c.va * ht) ? 1 : 0;
    if (t == 0) begin
      o.x = 0; o.y = 0; o.addr = 0; o.vis = 0;
      o.hs = 1 - c.hpol; o.vs = 1 - c.vpol;
      o.r = 0; o.g = 0; o.b = 0;
    end else begin
      p  = (t - 1) % ft;
      ph = p % ht;
      pv = p / ht;
      o.hs = (ph >= c.ha + c.hf && ph < c.ha + c.hf + c.hsw) ? c.hpol : 1 - c.hpol;
      o.vs = (pv >= c.va + c.vf && pv < c.va + c.vf + c.vsw) ? c.vpol : 1 - c.vpol;
      act  = (ph < c.ha && pv < c.va) ? 1 : 0;
      o.r  = act ? int'(rr) : 0;
      o.g  = act ? int'(gg) : 0;
      o.b  = act ? int'(bb) : 0;
      l    = (p + c.lat + 1) % ft;
      lx   = l % ht;
      ly   = l / ht;
      o.x  = lx;
      o.y  = ly;
      o.vis  = (lx < c.ha && ly < c.va) ? 1 : 0;
      o.addr = o.vis ? ((ly * c.ha + lx) & ((1 << 19) - 1)) : 0;
    end
    return o;
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL inst%0d %s: got %0d, expected %0d (t=%0t)", inst, name, act, want, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      cfg_t c;
      exp_t e;
      int   t, p, ht, vt;
      c  = get_cfg(i);
      e  = model(c, m[i], en, rl[i], gl[i], bl[i]);
      check("x", i, 32'(x_w[i]), e.x);
      check("y", i, 32'(y_w[i]), e.y);
      check("address", i, 32'(addr_w[i]), e.addr);
      check("visible", i, 32'(vis_w[i]), e.vis);
      check("pixelTick", i, 32'(pt_w[i]), e.pt);
      check("lineStart", i, 32'(ls_w[i]), e.ls);
      check("frameStart", i, 32'(fs_w[i]), e.fs);
      check("vblankStart", i, 32'(vbs_w[i]), e.vbs);
      check("hSync", i, 32'(hs_w[i]), e.hs);
      check("vSync", i, 32'(vs_w[i]), e.vs);
      check("vgaR", i, 32'(vr_w[i]), e.r);
      check("vgaG", i, 32'(vg_w[i]), e.g);
      check("vgaB", i, 32'(vbl_w[i]), e.b);
      // Sources fed from x: once the pipe is primed, red equals the column of the shown pixel.
      ht = c.ha + c.hf + c.hsw + c.hb;
      vt = c.va + c.vf + c.vsw + c.vb;
      t  = m[i] / c.div;
      if (i != 1 && t - 1 >= c.lat + 1) begin
        p = (t - 1) % (ht * vt);
        if (p % ht < c.ha && p / ht < c.va) check("vgaR_column", i, 32'(vr_w[i]), (p % ht) % 16);
      end
    end
  endtask

  always @(negedge clk) begin
    #2;
    compare_all();
  end

  task automatic step();
    @(negedge clk);
    #3;
    r1 = 4'($urandom);
    for (int i = 0; i < N; i++) begin
      g_in[i] = 4'($urandom);
      b_in[i] = 4'($urandom);
    end
  endtask

  int first [N];
  int line_st, cnt_clk, cnt_low, frm_st, cnt_vs;
  int nt, rst_hold, en_hold;
  bit prev_a_ls, prev_b_fs, prev_b_vbs, prev_c_fs;
  bit seen_a_ls, seen_b_fs, seen_b_vbs, seen_c_fs, seen_645, found;

  initial begin
    for (int i = 0; i < 3; i++) sh[i] = '0;
    r1 = '0;
    for (int i = 0; i < N; i++) begin
      g_in[i] = '0;
      b_in[i] = '0;
    end
    line_st = 0; frm_st = 0; cnt_clk = 0; cnt_low = 0; cnt_vs = 0;
    prev_a_ls = 0; prev_b_fs = 0; prev_b_vbs = 0; prev_c_fs = 0;
    seen_a_ls = 0; seen_b_fs = 0; seen_b_vbs = 0; seen_c_fs = 0; seen_645 = 0;

    #1 rst = 1'b1;
    repeat (3) step();
    check("b_hsync_idle_low", 1, 32'(hs_w[1]), 0);
    check("b_vsync_idle_low", 1, 32'(vs_w[1]), 0);
    check("a_hsync_idle_high", 0, 32'(hs_w[0]), 1);

    rst = 1'b0;
    en  = 1'b1;
    #1;
    for (int i = 0; i < N; i++) first[i] = pt_w[i] ? 1 : -1;

    for (int k = 1; k <= 4000; k++) begin
      step();
      for (int i = 0; i < N; i++) if (first[i] < 0 && pt_w[i]) first[i] = k + 1;

      if (prev_a_ls) begin
        check("a_after_line_x", 0, 32'(x_w[0]), 0);
        check("a_after_line_y", 0, 32'(y_w[0]), 1);
        check("a_after_line_vis", 0, 32'(vis_w[0]), 1);
        check("a_after_line_addr", 0, 32'(addr_w[0]), 640);
      end
      if (prev_b_fs) begin
        check("b_after_frame_x", 1, 32'(x_w[1]), 2);
        check("b_after_frame_y", 1, 32'(y_w[1]), 0);
        check("b_after_frame_vis", 1, 32'(vis_w[1]), 1);
        check("b_after_frame_addr", 1, 32'(addr_w[1]), 2);
      end
      if (prev_b_vbs) begin
        check("b_after_vblank_x", 1, 32'(x_w[1]), 2);
        check("b_after_vblank_y", 1, 32'(y_w[1]), 6);
        check("b_after_vblank_vis", 1, 32'(vis_w[1]), 0);
        check("b_after_vblank_addr", 1, 32'(addr_w[1]), 0);
      end
      if (prev_c_fs) begin
        check("c_after_frame_x", 2, 32'(x_w[2]), 3);
        check("c_after_frame_y", 2, 32'(y_w[2]), 0);
        check("c_after_frame_addr", 2, 32'(addr_w[2]), 3);
      end
      prev_a_ls = 0; prev_b_fs = 0; prev_b_vbs = 0; prev_c_fs = 0;

      if (!seen_645 && x_w[0] == 10'd5 && y_w[0] == 10'd1 && vis_w[0]) begin
        check("a_address_645", 0, 32'(addr_w[0]), 645);
        seen_645 = 1;
      end

      // One full line of A: clk period and hSync low ticks.
      if (ls_w[0]) begin
        if (line_st == 1) begin
          check("a_line_clk", 0, cnt_clk, 1600);
          check("a_hsync_low_ticks", 0, cnt_low, 96);
          line_st = 2;
        end else if (line_st == 0) begin
          line_st = 1; cnt_clk = 0; cnt_low = 0;
          prev_a_ls = 1; seen_a_ls = 1;
        end
      end
      if (line_st == 1) begin
        cnt_clk++;
        if (pt_w[0] && !hs_w[0]) cnt_low++;
      end

      // One full frame of B: vSync asserted (high) for two lines of 32 ticks.
      if (fs_w[1]) begin
        check("b_line_with_frame", 1, 32'(ls_w[1]), 1);
        if (frm_st == 1) begin
          check("b_vsync_active_ticks", 1, cnt_vs, 64);
          frm_st = 2;
        end else if (frm_st == 0) begin
          frm_st = 1; cnt_vs = 0;
        end
        if (!seen_b_fs) begin prev_b_fs = 1; seen_b_fs = 1; end
      end
      if (frm_st == 1 && pt_w[1] && vs_w[1]) cnt_vs++;

      if (vbs_w[1] && !seen_b_vbs) begin prev_b_vbs = 1; seen_b_vbs = 1; end
      if (fs_w[2] && !seen_c_fs) begin prev_c_fs = 1; seen_c_fs = 1; end
    end

    check("a_first_tick_edge", 0, first[0], 2);
    check("b_first_tick_edge", 1, first[1], 1);
    check("c_first_tick_edge", 2, first[2], 3);
    check("a_line_pair_seen", 0, line_st, 2);
    check("b_frame_pair_seen", 1, frm_st, 2);
    check("a_addr_645_seen", 0, 32'(seen_645), 1);
    check("b_vblank_seen", 1, 32'(seen_b_vbs), 1);
    check("c_frame_seen", 2, 32'(seen_c_fs), 1);

    // Enable dropped mid-frame, then raster restart and vblank after six lines of B.
    en = 1'b0;
    repeat (100) step();
    check("a_x_disabled", 0, 32'(x_w[0]), 0);
    check("a_hsync_disabled", 0, 32'(hs_w[0]), 1);
    check("b_hsync_disabled", 1, 32'(hs_w[1]), 0);
    check("c_vis_disabled", 2, 32'(vis_w[2]), 0);
    en = 1'b1;
    #1;
    nt = 0;
    found = 0;
    for (int k = 0; k < 1000 && !found; k++) begin
      if (pt_w[1]) nt++;
      if (vbs_w[1]) found = 1;
      else step();
    end
    check("b_reenable_vblank_seen", 1, 32'(found), 1);
    check("b_ticks_to_vblank", 1, nt, 192);

    // Asynchronous reset in the middle of a line.
    repeat (37) step();
    rst = 1'b1;
    #1;
    check("a_async_rst_x", 0, 32'(x_w[0]), 0);
    check("b_async_rst_hsync", 1, 32'(hs_w[1]), 0);
    check("c_async_rst_vgaR", 2, 32'(vr_w[2]), 0);
    compare_all();
    repeat (3) step();
    rst = 1'b0;

    rst_hold = 0;
    en_hold  = 0;
    for (int k = 0; k < 6000; k++) begin
      step();
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b0;
      end else if (en_hold > 0) begin
        en_hold--;
        if (en_hold == 0) en = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        rst_hold = $urandom_range(1, 4);
      end else if ($urandom_range(0, 299) == 0) begin
        en = 1'b0;
        en_hold = $urandom_range(5, 60);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
